// File: rtl/ctrl_pipe.sv
// Registered ID/EX decode/control stage for the 5-stage WISC-SP22 core.
// Detects load-use stalls, squashes on taken branches, handles SIIC/RTI/EPC and drains on HALT.
module ctrl_pipe #(
  parameter int unsigned       PC_W         = 16,
  parameter logic [PC_W-1:0]   EXC_VECTOR   = PC_W'(16'h0002),
  parameter int unsigned       DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     id_instr_i,
  input  logic            id_valid_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic            ex_br_taken_i,
  output logic [22:0]     ex_ctrl_o,
  output logic [2:0]      ex_rd_o,
  output logic            ex_valid_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [PC_W-1:0] epc_o,
  output logic            halt_o
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] ALU_ROL  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SLBI = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef struct packed {
    logic [1:0] alu_src;
    logic       zero_ext;
    logic [1:0] reg_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       jump;
    logic       imm_src;
    logic [2:0] br_control;
    logic [2:0] alu_op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       stu;
    logic       btr;
    logic       lbi;
    logic       set_if;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0] epc_q, epc_d;
  ctrl_t           ex_ctrl_q, ex_ctrl_d;
  logic [2:0]      ex_rd_q, ex_rd_d;
  logic            ex_valid_q, ex_valid_d;

  ctrl_t      dec;
  logic [1:0] reg_dest;
  logic       uses_rs, uses_rt;
  logic [4:0] opcode;
  logic [2:0] rs, rt, dec_rd;
  logic       halt_id, siic_id, rti_id, hazard, in_run;
  logic       stall_c, flush_c, redirect_c, bubble;
  logic [PC_W-1:0] redirect_pc_c;

  assign opcode = id_instr_i[15:11];
  assign rs     = id_instr_i[10:8];
  assign rt     = id_instr_i[7:5];

  // Opcode decode; alu_src 01 selects the immediate, reg_src 10 selects PC+2.
  always_comb begin
    dec      = '0;
    reg_dest = 2'b00;
    uses_rs  = 1'b1;
    uses_rt  = 1'b0;
    case (opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011: uses_rs = 1'b0;
      5'b00100: begin dec.jump = 1'b1; uses_rs = 1'b0; end
      5'b00101: begin dec.jump = 1'b1; dec.alu_src = 2'b01; dec.alu_op = ALU_ADD; dec.imm_src = 1'b1; end
      5'b00110: begin
        dec.jump = 1'b1; dec.reg_write = 1'b1; dec.reg_src = 2'b10; reg_dest = 2'b11; uses_rs = 1'b0;
      end
      5'b00111: begin
        dec.jump = 1'b1; dec.alu_src = 2'b01; dec.alu_op = ALU_ADD; dec.imm_src = 1'b1;
        dec.reg_write = 1'b1; dec.reg_src = 2'b10; reg_dest = 2'b11;
      end
      5'b01000: begin dec.alu_src = 2'b01; dec.reg_write = 1'b1; dec.alu_op = ALU_ADD; end
      5'b01001: begin
        dec.alu_src = 2'b01; dec.reg_write = 1'b1; dec.alu_op = ALU_ADD; dec.inv_a = 1'b1; dec.cin = 1'b1;
      end
      5'b01010: begin dec.alu_src = 2'b01; dec.reg_write = 1'b1; dec.alu_op = ALU_XOR; dec.zero_ext = 1'b1; end
      5'b01011: begin
        dec.alu_src = 2'b01; dec.reg_write = 1'b1; dec.alu_op = ALU_AND; dec.zero_ext = 1'b1; dec.inv_b = 1'b1;
      end
      5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
        dec.br_control = {1'b1, opcode[1:0]}; dec.imm_src = 1'b1;
      end
      5'b10000: begin dec.alu_src = 2'b01; dec.alu_op = ALU_ADD; dec.mem_write = 1'b1; uses_rt = 1'b1; end
      5'b10001: begin
        dec.alu_src = 2'b01; dec.alu_op = ALU_ADD; dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.reg_src = 2'b01;
      end
      5'b10010: begin
        dec.alu_src = 2'b01; dec.zero_ext = 1'b1; dec.imm_src = 1'b1; dec.alu_op = ALU_SLBI;
        dec.reg_write = 1'b1; reg_dest = 2'b01;
      end
      5'b10011: begin
        dec.alu_src = 2'b01; dec.alu_op = ALU_ADD; dec.mem_write = 1'b1; dec.reg_write = 1'b1;
        dec.stu = 1'b1; reg_dest = 2'b01; uses_rt = 1'b1;
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        dec.alu_src = 2'b01; dec.alu_op = {1'b0, opcode[1:0]}; dec.reg_write = 1'b1;
      end
      5'b11000: begin dec.lbi = 1'b1; dec.imm_src = 1'b1; dec.reg_write = 1'b1; reg_dest = 2'b01; uses_rs = 1'b0; end
      5'b11001: begin dec.btr = 1'b1; dec.reg_write = 1'b1; reg_dest = 2'b10; end
      5'b11010: begin
        dec.alu_op = ALU_ROL | {1'b0, id_instr_i[1:0]}; dec.reg_write = 1'b1; reg_dest = 2'b10; uses_rt = 1'b1;
      end
      5'b11011: begin
        dec.reg_write = 1'b1; reg_dest = 2'b10; uses_rt = 1'b1;
        case (id_instr_i[1:0])
          2'b00:   dec.alu_op = ALU_ADD;
          2'b01:   begin dec.alu_op = ALU_ADD; dec.inv_a = 1'b1; dec.cin = 1'b1; end
          2'b10:   dec.alu_op = ALU_XOR;
          default: begin dec.alu_op = ALU_AND; dec.inv_b = 1'b1; end
        endcase
      end
      default: begin
        // Set-if group: br_control[1:0] picks SEQ/SLT/SLE/SCO; SCO needs a true add.
        dec.set_if = 1'b1; dec.reg_write = 1'b1; reg_dest = 2'b10; uses_rt = 1'b1; dec.alu_op = ALU_ADD;
        dec.br_control = {1'b0, opcode[1:0]};
        dec.inv_b = (opcode[1:0] != 2'b11); dec.cin = (opcode[1:0] != 2'b11);
      end
    endcase
  end

  always_comb begin
    case (reg_dest)
      2'b00:   dec_rd = id_instr_i[7:5];
      2'b01:   dec_rd = id_instr_i[10:8];
      2'b10:   dec_rd = id_instr_i[4:2];
      default: dec_rd = 3'd7;
    endcase
  end

  assign in_run  = (state_q == RUN);
  assign halt_id = id_valid_i & (opcode == 5'b00000) & ~ex_br_taken_i;
  assign siic_id = id_valid_i & (opcode == 5'b00010) & ~ex_br_taken_i;
  assign rti_id  = id_valid_i & (opcode == 5'b00011) & ~ex_br_taken_i;
  assign hazard  = ex_valid_q & ex_ctrl_q.mem_read & id_valid_i &
                   ((uses_rs & (ex_rd_q == rs)) | (uses_rt & (ex_rd_q == rt)));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (halt_id) begin
        state_d = DRAIN;
        cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
      end
      DRAIN: if (cnt_q == '0) state_d = HALTED;
             else cnt_d = cnt_q - CNT_W'(1);
      default: state_d = HALTED;
    endcase
  end

  // FSM: outputs; flush wins over stall, DRAIN/HALTED ignore branches
  always_comb begin
    flush_c       = in_run & (ex_br_taken_i | siic_id | rti_id);
    stall_c       = ~in_run | (~flush_c & (hazard | halt_id));
    redirect_c    = in_run & (siic_id | rti_id);
    redirect_pc_c = '0;
    if (in_run & siic_id)     redirect_pc_c = EXC_VECTOR;
    else if (in_run & rti_id) redirect_pc_c = epc_q;
    bubble        = ~id_valid_i | flush_c | stall_c;
  end

  always_comb begin
    epc_d      = epc_q;
    if (in_run & siic_id) epc_d = id_pc_i + PC_W'(2);
    ex_ctrl_d  = bubble ? ctrl_t'('0) : dec;
    ex_rd_d    = bubble ? 3'd0 : dec_rd;
    ex_valid_d = ~bubble;
  end

  // ID/EX register and EPC
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= '0;
      ex_rd_q    <= '0;
      ex_valid_q <= 1'b0;
      epc_q      <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      ex_valid_q <= ex_valid_d;
      epc_q      <= epc_d;
    end
  end

  assign ex_ctrl_o     = ex_ctrl_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_valid_o    = ex_valid_q;
  assign epc_o         = epc_q;
  assign stall_o       = stall_c;
  assign flush_o       = flush_c;
  assign redirect_o    = redirect_c;
  assign redirect_pc_o = redirect_pc_c;
  assign halt_o        = (state_q == HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: hazards, flush, SIIC/RTI, halt drain and reset.
module tb_ctrl_pipe;

  logic        clk, rst;
  logic [15:0] id_instr;
  logic        id_valid;
  logic [15:0] id_pc;
  logic        ex_br_taken;
  logic [22:0] ex_ctrl;
  logic [2:0]  ex_rd;
  logic        ex_valid, stall, flush, redirect, halt;
  logic [15:0] redirect_pc, epc;

  int passed = 0;
  int total  = 0;

  localparam logic [15:0] I_LD_R1   = 16'h8820; // LD R1, R0, 0
  localparam logic [15:0] I_ADD     = 16'hD968; // ADD R2, R1, R3
  localparam logic [15:0] I_ADDI_NH = 16'h4220; // ADDI R1, R2, 0
  localparam logic [15:0] I_ST_R1   = 16'h8020; // ST R1, R0, 0
  localparam logic [15:0] I_ADDI    = 16'h4581; // ADDI R4, R5, 1
  localparam logic [15:0] I_HALT    = 16'h0000;
  localparam logic [15:0] I_NOP     = 16'h0800;
  localparam logic [15:0] I_SIIC    = 16'h1000;
  localparam logic [15:0] I_RTI     = 16'h1800;

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_instr_i(id_instr), .id_valid_i(id_valid), .id_pc_i(id_pc), .ex_br_taken_i(ex_br_taken),
    .ex_ctrl_o(ex_ctrl), .ex_rd_o(ex_rd), .ex_valid_o(ex_valid),
    .stall_o(stall), .flush_o(flush), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .epc_o(epc), .halt_o(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one ID slot at the falling edge; it commits on the following rising edge.
  task automatic cyc(input logic [15:0] ins, input logic v, input logic [15:0] pc, input logic br);
    @(negedge clk);
    id_instr    = ins;
    id_valid    = v;
    id_pc       = pc;
    ex_br_taken = br;
    #1;
  endtask

  task automatic idle();
    cyc(16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_instr = '0; id_valid = 1'b0; id_pc = '0; ex_br_taken = 1'b0;
    idle(); idle();
    rst = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_ctrl",  32'(ex_ctrl),  32'd0);
    chk("rst_ex_rd",    32'(ex_rd),    32'd0);
    chk("rst_halt",     32'(halt),     32'd0);
    chk("rst_epc",      32'(epc),      32'd0);
    chk("rst_stall",    32'(stall),    32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);

    // Load-use on Rs: one stall cycle, then ADD enters EX
    cyc(I_LD_R1, 1'b1, 16'h0010, 1'b0);
    chk("ld_nostall", 32'(stall), 32'd0);
    cyc(I_ADD, 1'b1, 16'h0012, 1'b0);
    chk("ld_in_ex_valid", 32'(ex_valid), 32'd1);
    chk("ld_in_ex_memrd", 32'(ex_ctrl[15]), 32'd1);
    chk("ld_in_ex_rd",    32'(ex_rd), 32'd1);
    chk("lu_stall",       32'(stall), 32'd1);
    chk("lu_flush",       32'(flush), 32'd0);
    cyc(I_ADD, 1'b1, 16'h0012, 1'b0);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_release", 32'(stall), 32'd0);
    idle();
    chk("add_ex_valid", 32'(ex_valid), 32'd1);
    chk("add_regwrite", 32'(ex_ctrl[17]), 32'd1);
    chk("add_ex_rd",    32'(ex_rd), 32'd2);
    chk("add_ex_ctrl",  32'(ex_ctrl), 32'h0002_0200);

    // ADDI does not read [7:5]; ST does
    cyc(I_LD_R1, 1'b1, 16'h0020, 1'b0);
    cyc(I_ADDI_NH, 1'b1, 16'h0022, 1'b0);
    chk("addi_no_rt_hazard", 32'(stall), 32'd0);
    cyc(I_LD_R1, 1'b1, 16'h0024, 1'b0);
    cyc(I_ST_R1, 1'b1, 16'h0026, 1'b0);
    chk("st_rt_hazard", 32'(stall), 32'd1);
    idle();

    // Load-use together with taken branch: flush wins
    cyc(I_LD_R1, 1'b1, 16'h0030, 1'b0);
    cyc(I_ADD, 1'b1, 16'h0032, 1'b1);
    chk("br_flush",    32'(flush), 32'd1);
    chk("br_nostall",  32'(stall), 32'd0);
    chk("br_noredir",  32'(redirect), 32'd0);
    idle();
    chk("br_bubble", 32'(ex_valid), 32'd0);
    idle();
    chk("br_add_gone", 32'(ex_valid), 32'd0);

    // NOP enters EX; SIIC squashed by branch
    cyc(I_NOP, 1'b1, 16'h0050, 1'b0);
    cyc(I_SIIC, 1'b1, 16'h0052, 1'b1);
    chk("nop_valid",  32'(ex_valid), 32'd1);
    chk("nop_ctrl",   32'(ex_ctrl), 32'd0);
    chk("siicsq_redir",   32'(redirect), 32'd0);
    chk("siicsq_redirpc", 32'(redirect_pc), 32'd0);
    chk("siicsq_flush",   32'(flush), 32'd1);
    idle();
    chk("siicsq_epc",   32'(epc), 32'd0);
    chk("siicsq_bubble", 32'(ex_valid), 32'd0);

    // SIIC then RTI
    cyc(I_SIIC, 1'b1, 16'h0040, 1'b0);
    chk("siic_redir",   32'(redirect), 32'd1);
    chk("siic_redirpc", 32'(redirect_pc), 32'h0002);
    chk("siic_flush",   32'(flush), 32'd1);
    chk("siic_nostall", 32'(stall), 32'd0);
    idle();
    chk("siic_epc",    32'(epc), 32'h0042);
    chk("siic_bubble", 32'(ex_valid), 32'd0);
    cyc(I_RTI, 1'b1, 16'h0002, 1'b0);
    chk("rti_redir",   32'(redirect), 32'd1);
    chk("rti_redirpc", 32'(redirect_pc), 32'h0042);
    chk("rti_flush",   32'(flush), 32'd1);
    idle();
    chk("rti_bubble",   32'(ex_valid), 32'd0);
    chk("idle_redir",   32'(redirect), 32'd0);
    chk("idle_redirpc", 32'(redirect_pc), 32'd0);

    // EPC wraps modulo 2^16
    cyc(I_SIIC, 1'b1, 16'hFFFE, 1'b0);
    idle();
    chk("epc_wrap", 32'(epc), 32'h0000);

    // HALT drain: halt rises DRAIN_CYCLES+1 cycles later, branches ignored
    cyc(I_HALT, 1'b1, 16'h0060, 1'b0);
    chk("halt_id_stall", 32'(stall), 32'd1);
    chk("halt_id_halt",  32'(halt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc(I_ADD, 1'b1, 16'h0062, (k == 2));
      chk("drain_stall", 32'(stall), 32'd1);
      chk("drain_halt",  32'(halt), 32'd0);
      chk("drain_flush", 32'(flush), 32'd0);
      chk("drain_valid", 32'(ex_valid), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(I_ADD, 1'b1, 16'h0062, 1'b0);
      chk("halted_halt",  32'(halt), 32'd1);
      chk("halted_stall", 32'(stall), 32'd1);
      chk("halted_valid", 32'(ex_valid), 32'd0);
    end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("unhalt_halt", 32'(halt), 32'd0);

    // Reset during second DRAIN cycle clears FSM and EPC
    cyc(I_SIIC, 1'b1, 16'h0100, 1'b0);
    idle();
    chk("epc_pre_rst", 32'(epc), 32'h0102);
    cyc(I_HALT, 1'b1, 16'h0104, 1'b0);
    idle();
    idle();
    chk("drain2_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mid_rst_halt",  32'(halt), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_epc",   32'(epc), 32'd0);
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    cyc(I_ADDI, 1'b1, 16'h0000, 1'b0);
    chk("addi_nostall", 32'(stall), 32'd0);
    idle();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_rd",    32'(ex_rd), 32'd4);
    chk("addi_ctrl",  32'(ex_ctrl), 32'h0022_0200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
